// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared types, legality limits and compare-mask helper for seq_detect_param
package seq_detect_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    FILL     = 2'd1,
    ARMED    = 2'd2
  } state_t;

  localparam int MIN_LEN_LIMIT = 2;
  localparam int MAX_LEN_LIMIT = 32;

  // Ones in the low len bit positions; callers truncate to their own MAX_LEN.
  function automatic logic [MAX_LEN_LIMIT-1:0] len_mask(input int unsigned len);
    if (len >= MAX_LEN_LIMIT) return '1;
    return (MAX_LEN_LIMIT'(1) << len) - MAX_LEN_LIMIT'(1);
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// rtl/seq_detect_param_if.sv - configuration, serial input and status signals of seq_detect_param
interface seq_detect_param_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               inp_valid;
  logic               inp_bit;
  logic               count_clr;
  logic               seq_seen;
  logic               cfg_err;
  logic               armed;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, inp_valid, inp_bit, count_clr,
    input  seq_seen, cfg_err, armed, match_count
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, inp_valid, inp_bit, count_clr,
    output seq_seen, cfg_err, armed, match_count
  );
endinterface

// File: rtl/seq_match_counter.sv
// rtl/seq_match_counter.sv - saturating match counter with synchronous clear (clear wins over increment)
module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - runtime-programmable serial pattern detector, overlapping or non-overlapping
// Optional match counter compiled in with SEQ_DETECT_MATCH_CNT_EN.
import seq_detect_pkg::*;

module seq_detect_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  seq_detect_param_if.slave bus
);

  state_t             state_q, state_d;
  // Only MAX_LEN-1 bits are stored: the oldest bit of a full-length window
  // is never needed again after the compare that shifts it out.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               seen_q, seen_d;
  logic               err_q, err_d;
  logic               armed_q, armed_d;
  logic [MAX_LEN-1:0] shifted;
  logic [MAX_LEN-1:0] mask;
  logic               cfg_legal;
  logic               hit;

  assign cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
  assign mask      = MAX_LEN'(len_mask(32'(len_q)));
  assign shifted   = {hist_q, bus.inp_bit};
  assign hit       = ((shifted ^ pat_q) & mask) == '0;
  assign fill_inc  = (fill_q == len_q) ? len_q : fill_q + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    seen_d  = 1'b0;
    err_d   = 1'b0;

    if (bus.cfg_we) begin
      if (cfg_legal) begin
        pat_d   = bus.cfg_pattern;
        len_d   = bus.cfg_len;
        ovl_d   = bus.cfg_overlap;
        hist_d  = '0;
        fill_d  = '0;
        state_d = FILL;
      end else begin
        err_d   = 1'b1;
        state_d = DISABLED;
      end
    end else if (bus.inp_valid && (state_q != DISABLED)) begin
      hist_d = shifted[MAX_LEN-2:0];
      fill_d = fill_inc;
      if (fill_inc == len_q) begin
        state_d = ARMED;
        if (hit) begin
          seen_d = 1'b1;
          if (!ovl_q) begin
            fill_d  = '0;
            state_d = FILL;
          end
        end
      end
    end

    armed_d = (state_d == ARMED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DISABLED;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      seen_q  <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
      armed_q <= armed_d;
    end
  end

  assign bus.seq_seen = seen_q;
  assign bus.cfg_err  = err_q;
  assign bus.armed    = armed_q;

`ifdef SEQ_DETECT_MATCH_CNT_EN
  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_match_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (seen_d),
    .clr   (bus.count_clr),
    .count (bus.match_count)
  );
`else
  logic count_clr_unused;
  assign count_clr_unused = bus.count_clr;
  assign bus.match_count  = CNT_W'(0);
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed and randomized checks of seq_detect_param against a queue-based model
module tb_seq_detect_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SEQ_DETECT_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_detect_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  bit               m_en;
  int               m_len;
  logic [MAX_LEN-1:0] m_pat;
  bit               m_ovl;
  int               m_fresh;
  bit               m_bits[$];
  int               m_cnt;
  bit               e_seen, e_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit tail_match();
    if (m_bits.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (m_bits[m_bits.size() - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_en = 0; m_len = 0; m_pat = '0; m_ovl = 0; m_fresh = 0;
    m_bits.delete(); m_cnt = 0; e_seen = 0; e_err = 0;
  endtask

  task automatic model_edge(input bit we, input logic [MAX_LEN-1:0] pat, input int len,
                            input bit ovl, input bit v, input bit b, input bit clr);
    e_seen = 0;
    e_err  = 0;
    if (we) begin
      if (len >= 1 && len <= MAX_LEN) begin
        m_en = 1; m_pat = pat; m_len = len; m_ovl = ovl; m_fresh = 0; m_bits.delete();
      end else begin
        m_en = 0; e_err = 1; m_fresh = 0;
      end
    end else if (v && m_en) begin
      m_bits.push_back(b);
      if (m_bits.size() > 40) void'(m_bits.pop_front());
      m_fresh++;
      if (m_fresh >= m_len && tail_match()) begin
        e_seen = 1;
        if (!m_ovl) m_fresh = 0;
      end
    end
    if (CNT_EN) begin
      if (clr) m_cnt = 0;
      else if (e_seen && m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  task automatic check_outs(input string tag);
    check($sformatf("%s.seen", tag),  32'(bus.seq_seen),    32'(e_seen));
    check($sformatf("%s.err", tag),   32'(bus.cfg_err),     32'(e_err));
    check($sformatf("%s.armed", tag), 32'(bus.armed),       32'(m_en && m_fresh >= m_len));
    check($sformatf("%s.count", tag), 32'(bus.match_count), 32'(m_cnt));
  endtask

  task automatic step(input string tag, input bit we, input logic [MAX_LEN-1:0] pat,
                      input int len, input bit ovl, input bit v, input bit b, input bit clr);
    @(negedge clk);
    bus.cfg_we      = we;
    bus.cfg_pattern = pat;
    bus.cfg_len     = LEN_W'(len);
    bus.cfg_overlap = ovl;
    bus.inp_valid   = v;
    bus.inp_bit     = b;
    bus.count_clr   = clr;
    @(posedge clk);
    model_edge(we, pat, len, ovl, v, b, clr);
    #1;
    check_outs(tag);
  endtask

  task automatic cfg(input string tag, input logic [MAX_LEN-1:0] pat, input int len, input bit ovl);
    step(tag, 1'b1, pat, len, ovl, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic bit_in(input string tag, input bit b);
    step(tag, 1'b0, '0, 0, 1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic gap(input string tag);
    step(tag, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mid_reset(input string tag);
    @(negedge clk);
    bus.cfg_we = 0; bus.inp_valid = 0; bus.count_clr = 0;
    reset = 1'b1;
    model_reset();
    #1;
    check_outs(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit legacy[7] = '{1, 0, 1, 1, 0, 1, 1};
    reset = 1'b1;
    bus.cfg_we = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 0;
    bus.inp_valid = 0; bus.inp_bit = 0; bus.count_clr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outs("reset");
    reset = 1'b0;

    cfg("legacy_ovl_cfg", 8'b1011, 4, 1'b1);
    foreach (legacy[i]) bit_in($sformatf("legacy_ovl_b%0d", i + 1), legacy[i]);
    check("legacy_ovl_total", 32'(bus.match_count), CNT_EN ? 32'd2 : 32'd0);

    step("legacy_nov_cfg", 1'b1, 8'b1011, 4, 1'b0, 1'b0, 1'b0, 1'b1);
    foreach (legacy[i]) bit_in($sformatf("legacy_nov_b%0d", i + 1), legacy[i]);
    check("legacy_nov_total", 32'(bus.match_count), CNT_EN ? 32'd1 : 32'd0);

    cfg("gaps_cfg", 8'b110, 3, 1'b1);
    bit_in("gaps_b1", 1'b1);
    gap("gaps_g1");
    bit_in("gaps_b2", 1'b1);
    gap("gaps_g2");
    gap("gaps_g3");
    bit_in("gaps_b3", 1'b0);
    check("gaps_pulse", 32'(bus.seq_seen), 32'd1);

    cfg("illegal_len0", 8'hFF, 0, 1'b1);
    repeat (4) bit_in("illegal_len0_bits", 1'b1);
    cfg("illegal_len9", 8'hFF, MAX_LEN + 1, 1'b1);
    repeat (4) bit_in("illegal_len9_bits", 1'b1);

    cfg("simul_cfg", 8'b11, 2, 1'b1);
    bit_in("simul_b1", 1'b1);
    step("simul_we_valid", 1'b1, 8'b11, 2, 1'b1, 1'b1, 1'b1, 1'b0);
    bit_in("simul_b2", 1'b1);
    bit_in("simul_b3", 1'b1);

    cfg("clr_cfg", 8'b1, 1, 1'b1);
    bit_in("clr_b1", 1'b1);
    step("clr_on_match", 1'b0, '0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("clr_on_match_zero", 32'(bus.match_count), 32'd0);

    repeat (5) bit_in("sat_bits", 1'b1);
    check("sat_hold", 32'(bus.match_count), CNT_EN ? 32'(CNT_MAX) : 32'd0);

    cfg("rst_cfg", 8'b101, 3, 1'b1);
    bit_in("rst_b1", 1'b1);
    bit_in("rst_b2", 1'b0);
    mid_reset("rst_mid");
    repeat (4) bit_in("rst_after_bits", 1'b1);
    cfg("rst_recfg", 8'b1, 1, 1'b0);
    bit_in("rst_recfg_b", 1'b1);

    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        int len;
        int sel;
        sel = $urandom_range(0, 9);
        len = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(MAX_LEN + 1, 15)
            : (sel < 4) ? $urandom_range(5, MAX_LEN) : $urandom_range(1, 4);
        step("rand_cfg", 1'b1, MAX_LEN'($urandom), len, 1'($urandom),
             1'($urandom), 1'($urandom), 1'b0);
      end else if (r == 4) begin
        mid_reset("rand_reset");
      end else begin
        step("rand_bit", 1'b0, '0, 0, 1'b0, $urandom_range(0, 3) != 0, 1'($urandom),
             $urandom_range(0, 19) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Runtime-programmable serial pattern detector for single-bit input streams, up to MAX_LEN bits long, with selectable overlapping or non-overlapping matching and an optional saturating match counter. It is the parametrised successor of the team's fixed-pattern 1011 detector. It sits on the same serial bit paths, adds a valid qualifier, and lets software reprogram pattern and length without a rebuild.

## Interface
Parameters:
- MAX_LEN, 8: maximum pattern length in bits; legal range 2..32.
- CNT_W, 8: match counter width.
- LEN_W, $clog2(MAX_LEN+1): width of cfg_len. Derived; do not override.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high; clock clk.
- cfg_we  in  1  load cfg_pattern, cfg_len and cfg_overlap this cycle.
- cfg_pattern  in  MAX_LEN  pattern. Bit cfg_len-1 is the first bit received; bit 0 is the last.
- cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- inp_valid  in  1  inp_bit is sampled only when high.
- inp_bit  in  1  serial data bit.
- count_clr  in  1  synchronous clear of match_count.
- seq_seen  out  1  one-cycle pulse; pattern completed by the previous accepted bit.
- cfg_err  out  1  one-cycle pulse; an illegal cfg_len was written.
- armed  out  1  history holds at least cfg_len bits.
- match_count  out  CNT_W  saturating count of matches.

## Operation
- The FSM has three states: DISABLED, FILL and ARMED. Reset enters DISABLED.
- cfg_we with 1 ≤ cfg_len ≤ MAX_LEN:
  - latches the configuration;
  - clears the history shift register and fill_cnt;
  - moves to FILL, from any state.
- cfg_we with cfg_len = 0 or cfg_len > MAX_LEN:
  - configuration is not latched;
  - cfg_err pulses;
  - moves to DISABLED.
- On an accepted bit (inp_valid and not cfg_we, state ≠ DISABLED):
  - hist <= {hist[MAX_LEN-2:0], inp_bit};
  - fill_cnt increments and saturates at cfg_len.
- FILL → ARMED when fill_cnt reaches cfg_len.
- Match condition: state ARMED (after this shift) and the low cfg_len bits of hist equal the low cfg_len bits of the pattern.
- On a match, seq_seen is set for one cycle. Then:
  - overlap = 1: stay ARMED; the history is retained.
  - overlap = 0: fill_cnt clears and the state returns to FILL. A further match needs cfg_len fresh bits.
- In DISABLED, input bits are ignored and seq_seen stays 0.
- Precedence:
  - cfg_we beats inp_valid; the bit arriving in that cycle is discarded.
  - count_clr beats a simultaneous match increment; the result is 0.

## Timing
- All outputs are registered. seq_seen, cfg_err and armed reset to 0, as does match_count when compiled in.
- Latency: a bit accepted at edge N raises seq_seen during cycle N to N+1.
- Back-to-back valid bits are accepted every cycle; there is no backpressure.
- Gaps in inp_valid do not disturb the history.
- armed reflects the state after each edge.
- match_count updates on the same edge that sets seq_seen.
- Reset mid-stream discards the configuration and history; the block is DISABLED until the next legal cfg_we.

## Configuration
- Macro: SEQ_DETECT_MATCH_CNT_EN.
- Defined: match_count increments once per match, holds at 2^CNT_W-1, and clears on count_clr.
- Undefined: the counter is not instantiated, match_count is tied to 0 and count_clr is ignored. All other behaviour is identical.

## Structure
- seq_detect_pkg holds:
  - the state enum (DISABLED, FILL, ARMED);
  - the MAX_LEN legality limits;
  - a mask function that builds the low-cfg_len-bit compare mask.
- Sub-module seq_match_counter: parametrised CNT_W saturating counter with increment and clear inputs, instantiated under SEQ_DETECT_MATCH_CNT_EN.

## Test plan
- **Legacy pattern, overlap.** Configure len=4, pattern=4'b1011, overlap=1. Stream 1,0,1,1,0,1,1 (valid every cycle) → seq_seen pulses after bit 4 and after bit 7; match_count=2.
- **Same stream, non-overlap.** overlap=0 → a single pulse after bit 4; armed drops after bit 4; match_count=1.
- **Valid gaps.** len=3, pattern=3'b110. Stream 1,(gap),1,(gap,gap),0 → one pulse one cycle after the final accepted bit.
- **Illegal length.** cfg_len=0, then cfg_len=MAX_LEN+1 → cfg_err pulses each time; state DISABLED; stream 1111 produces no seq_seen.
- **Simultaneous events.** cfg_we together with inp_valid → the bit is discarded and fill restarts. count_clr in the cycle of a match → match_count=0.
- **Saturation and reset.** CNT_W=2, 5 matches → match_count holds at 3. Assert reset mid-stream → all outputs 0, and no match until reconfigured.
